// File: rtl/arbitro_fifos.sv
// Round-robin arbiter between four upstream FIFOs and four downstream FIFOs.
// Pops one upstream FIFO per cycle and routes the word by its two MSBs; also owns the FIFO thresholds.
module arbitro_fifos #(
    parameter int DW = 6,
    parameter int UW = 4
) (
    input  logic            clk,
    input  logic            reset_L,
    input  logic            init,
    input  logic [UW-1:0]   umbral_lleno_in,
    input  logic [UW-1:0]   umbral_vacio_in,
    input  logic [3:0]      fifo_empty_in,
    input  logic [3:0]      valid_in,
    input  logic [4*DW-1:0] data_in,
    input  logic [3:0]      almost_full_in,
    input  logic [7:0]      error_in,
    output logic [3:0]      pop,
    output logic [3:0]      push,
    output logic [DW-1:0]   data_out,
    output logic [UW-1:0]   umbral_casi_lleno,
    output logic [UW-1:0]   umbral_casi_vacio,
    output logic [2:0]      estado,
    output logic            error_out
);

    typedef enum logic [2:0] {
        RESET  = 3'd0,
        INIT   = 3'd1,
        IDLE   = 3'd2,
        ACTIVE = 3'd3,
        ERROR  = 3'd4
    } state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [1:0]    grant;
    logic [1:0]    idx;
    logic          any_ne;
    logic          multi_vld;
    logic          err_det;
    logic          pop_en;
    logic          pop_p0;
    logic          in_flight;
    logic          fwd_ok;
    logic [DW-1:0] word_sel;

    function automatic logic [3:0] onehot(input logic [1:0] sel);
        onehot = 4'b0001 << sel;
    endfunction

    // Descending search so the nearest non-empty FIFO after ptr wins; ptr itself is checked last.
    always_comb begin
        grant = ptr;
        idx   = ptr;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (!fifo_empty_in[idx]) begin
                grant = idx;
            end
        end
    end

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < 4; i++) begin
            if (valid_in[i]) begin
                word_sel = data_in[DW*i +: DW];
            end
        end
    end

    assign any_ne    = ~&fifo_empty_in;
    assign multi_vld = (valid_in & (valid_in - 4'd1)) != 4'd0;
    assign err_det   = (|error_in) | multi_vld;
    assign pop_en    = (state == ACTIVE) && !init && !(|error_in) && !(|almost_full_in) && any_ne;
    assign pop       = pop_en ? onehot(grant) : 4'b0000;
    assign in_flight = pop_p0 | (|valid_in);
    assign fwd_ok    = (|valid_in) && !err_det &&
                       (state == INIT || state == IDLE || state == ACTIVE);
    assign estado    = state;
    assign error_out = (state == ERROR);

    // Stage p0: pop issued -> upstream word arrives next cycle -> registered push toward its destination.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state             <= RESET;
            ptr               <= 2'd3;
            pop_p0            <= 1'b0;
            push              <= 4'b0000;
            data_out          <= '0;
            umbral_casi_lleno <= '0;
            umbral_casi_vacio <= '0;
        end else begin
            pop_p0 <= pop_en;
            if (pop_en) begin
                ptr <= grant;
            end

            push <= 4'b0000;
            if (fwd_ok) begin
                push     <= onehot(word_sel[DW-1:DW-2]);
                data_out <= word_sel;
            end

            case (state)
                RESET: state <= INIT;
                ERROR: state <= ERROR;
                default: begin
                    if (err_det) begin
                        state <= ERROR;
                    end else begin
                        case (state)
                            INIT: begin
                                umbral_casi_lleno <= umbral_lleno_in;
                                umbral_casi_vacio <= umbral_vacio_in;
                                if (!init) state <= IDLE;
                            end
                            IDLE: begin
                                if (init)        state <= INIT;
                                else if (any_ne) state <= ACTIVE;
                            end
                            ACTIVE: begin
                                if (init)                        state <= INIT;
                                else if (!any_ne && !in_flight) state <= IDLE;
                            end
                            default: state <= state;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_fifos.sv
// Directed bench for arbitro_fifos: models four upstream FIFOs and scoreboards every downstream push.
module tb_arbitro_fifos;
    localparam int DW = 6;
    localparam int UW = 4;

    logic            clk = 1'b0;
    logic            reset_L;
    logic            init;
    logic [UW-1:0]   umbral_lleno_in;
    logic [UW-1:0]   umbral_vacio_in;
    logic [3:0]      fifo_empty_in;
    logic [3:0]      valid_in;
    logic [4*DW-1:0] data_in;
    logic [3:0]      almost_full_in;
    logic [7:0]      error_in;
    logic [3:0]      pop;
    logic [3:0]      push;
    logic [DW-1:0]   data_out;
    logic [UW-1:0]   umbral_casi_lleno;
    logic [UW-1:0]   umbral_casi_vacio;
    logic [2:0]      estado;
    logic            error_out;

    int nvec = 0;
    int nerr = 0;
    logic [9:0]    sb[$];
    logic [DW-1:0] fmem[4][16];
    int            rd[4];
    int            wr[4];
    logic [3:0]    pop_s;

    always #5 clk = ~clk;

    arbitro_fifos #(.DW(DW), .UW(UW)) dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .umbral_lleno_in(umbral_lleno_in), .umbral_vacio_in(umbral_vacio_in),
        .fifo_empty_in(fifo_empty_in), .valid_in(valid_in), .data_in(data_in),
        .almost_full_in(almost_full_in), .error_in(error_in),
        .pop(pop), .push(push), .data_out(data_out),
        .umbral_casi_lleno(umbral_casi_lleno), .umbral_casi_vacio(umbral_casi_vacio),
        .estado(estado), .error_out(error_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd_empty();
        for (int i = 0; i < 4; i++) fifo_empty_in[i] = (rd[i] == wr[i]);
    endtask

    task automatic load(input int f, input logic [DW-1:0] w);
        fmem[f][wr[f]] = w;
        wr[f]++;
        upd_empty();
    endtask

    task automatic check_push();
        logic [9:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("push", 32'(push), 32'(e[9:6]));
            chk("data_out", 32'(data_out), 32'(e[5:0]));
        end else begin
            chk("push_idle", 32'(push), 32'd0);
        end
    endtask

    // One clock: sample pop mid-cycle, then after the edge check push and let the upstream model respond.
    task automatic tick();
        logic [DW-1:0] w;
        logic [3:0]    oh;
        #2;
        pop_s = pop;
        @(posedge clk);
        #1;
        check_push();
        valid_in = 4'b0000;
        data_in  = '0;
        for (int i = 0; i < 4; i++) begin
            if (pop_s[i] && rd[i] != wr[i]) begin
                w = fmem[i][rd[i]];
                rd[i]++;
                valid_in[i] = 1'b1;
                data_in[i*DW +: DW] = w;
                oh = 4'b0000;
                oh[w[DW-1:DW-2]] = 1'b1;
                sb.push_back({oh, w});
            end
        end
        upd_empty();
    endtask

    task automatic tick_pop(input string tag, input logic [3:0] exp);
        tick();
        chk(tag, 32'(pop_s), 32'(exp));
    endtask

    task automatic hard_reset();
        reset_L  = 1'b0;
        valid_in = 4'b0000;
        data_in  = '0;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        upd_empty();
        #1;
        chk("rst_estado", 32'(estado), 32'd0);
        chk("rst_push", 32'(push), 32'd0);
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_error_out", 32'(error_out), 32'd0);
        chk("rst_umbral_lleno", 32'(umbral_casi_lleno), 32'd0);
    endtask

    task automatic do_init(input logic [UW-1:0] ll, input logic [UW-1:0] va);
        @(negedge clk);
        reset_L         = 1'b1;
        init            = 1'b1;
        umbral_lleno_in = ll;
        umbral_vacio_in = va;
        tick();
        chk("init_enter", 32'(estado), 32'd1);
        tick();
        init = 1'b0;
        tick();
        chk("init_idle", 32'(estado), 32'd2);
        chk("init_lleno", 32'(umbral_casi_lleno), 32'(ll));
        chk("init_vacio", 32'(umbral_casi_vacio), 32'(va));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_L = 1'b1; init = 1'b0; umbral_lleno_in = '0; umbral_vacio_in = '0;
        valid_in = 4'b0000; data_in = '0; almost_full_in = 4'b0000; error_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        upd_empty();
        #1 reset_L = 1'b0;
        #2;
        chk("rst_estado", 32'(estado), 32'd0);
        chk("rst_push", 32'(push), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_umbral_lleno", 32'(umbral_casi_lleno), 32'd0);
        chk("rst_umbral_vacio", 32'(umbral_casi_vacio), 32'd0);
        chk("rst_error_out", 32'(error_out), 32'd0);
        chk("rst_pop", 32'(pop), 32'd0);

        // Configuration: three INIT cycles, then IDLE with thresholds 6/2
        @(negedge clk);
        reset_L = 1'b1; init = 1'b1; umbral_lleno_in = 4'd6; umbral_vacio_in = 4'd2;
        tick_pop("cfg_pop0", 4'b0000);
        chk("cfg_estado0", 32'(estado), 32'd1);
        chk("cfg_lleno0", 32'(umbral_casi_lleno), 32'd0);
        tick_pop("cfg_pop1", 4'b0000);
        chk("cfg_estado1", 32'(estado), 32'd1);
        chk("cfg_lleno1", 32'(umbral_casi_lleno), 32'd6);
        tick_pop("cfg_pop2", 4'b0000);
        chk("cfg_estado2", 32'(estado), 32'd1);
        init = 1'b0;
        tick_pop("cfg_pop3", 4'b0000);
        chk("cfg_estado3", 32'(estado), 32'd2);
        chk("cfg_lleno", 32'(umbral_casi_lleno), 32'd6);
        chk("cfg_vacio", 32'(umbral_casi_vacio), 32'd2);

        // Round robin across all four FIFOs, every word routed to downstream 2
        load(0, 6'b10_0001); load(0, 6'b10_0101);
        load(1, 6'b10_0010); load(2, 6'b10_0011); load(3, 6'b10_0100);
        tick_pop("rr_idle", 4'b0000);
        chk("rr_active", 32'(estado), 32'd3);
        tick_pop("rr_pop0", 4'b0001);
        tick_pop("rr_pop1", 4'b0010);
        tick_pop("rr_pop2", 4'b0100);
        tick_pop("rr_pop3", 4'b1000);
        tick_pop("rr_pop4", 4'b0001);
        tick_pop("rr_drain0", 4'b0000);
        chk("rr_inflight", 32'(estado), 32'd3);
        tick_pop("rr_drain1", 4'b0000);
        chk("rr_back_idle", 32'(estado), 32'd2);

        // Single non-empty FIFO granted back-to-back, mixed destinations
        load(2, 6'b00_0110); load(2, 6'b01_0111); load(2, 6'b11_1000);
        tick_pop("solo_idle", 4'b0000);
        tick_pop("solo_pop0", 4'b0100);
        tick_pop("solo_pop1", 4'b0100);
        tick_pop("solo_pop2", 4'b0100);
        tick_pop("solo_drain0", 4'b0000);
        tick_pop("solo_drain1", 4'b0000);
        chk("solo_idle_end", 32'(estado), 32'd2);

        // Backpressure mid-stream; in-flight words still land, then resume at pointer+1
        load(0, 6'b01_0001); load(0, 6'b01_0010); load(0, 6'b01_0011);
        load(1, 6'b01_1001); load(1, 6'b01_1010); load(1, 6'b01_1011);
        tick_pop("af_idle", 4'b0000);
        tick_pop("af_pop0", 4'b0001);
        tick_pop("af_pop1", 4'b0010);
        almost_full_in = 4'b0010;
        tick_pop("af_block0", 4'b0000);
        tick_pop("af_block1", 4'b0000);
        chk("af_state", 32'(estado), 32'd3);
        almost_full_in = 4'b0000;
        tick_pop("af_resume0", 4'b0001);
        tick_pop("af_resume1", 4'b0010);
        tick_pop("af_resume2", 4'b0001);
        tick_pop("af_resume3", 4'b0010);
        tick_pop("af_drain0", 4'b0000);
        tick_pop("af_drain1", 4'b0000);
        chk("af_idle_end", 32'(estado), 32'd2);

        // Downstream error pulse in ACTIVE: sticky ERROR
        load(3, 6'b00_0001); load(3, 6'b00_0010);
        tick_pop("err_idle", 4'b0000);
        chk("err_active", 32'(estado), 32'd3);
        error_in = 8'h20;
        tick_pop("err_pop_gated", 4'b0000);
        chk("err_estado", 32'(estado), 32'd4);
        chk("err_out", 32'(error_out), 32'd1);
        error_in = 8'h00;
        tick_pop("err_hold_pop0", 4'b0000);
        tick_pop("err_hold_pop1", 4'b0000);
        chk("err_sticky", 32'(estado), 32'd4);
        chk("err_out_sticky", 32'(error_out), 32'd1);

        hard_reset();
        do_init(4'd5, 4'd3);

        // Two valids in one cycle
        valid_in = 4'b0011;
        data_in  = {6'd0, 6'd0, 6'b10_1010, 6'b01_0101};
        tick();
        chk("mv_estado", 32'(estado), 32'd4);
        chk("mv_error_out", 32'(error_out), 32'd1);
        tick();
        chk("mv_sticky", 32'(estado), 32'd4);

        hard_reset();
        do_init(4'd6, 4'd2);

        // Reset with a word in flight: nothing pushed afterwards, pointer back to 3
        load(1, 6'b11_0101);
        tick_pop("rif_idle", 4'b0000);
        tick_pop("rif_pop", 4'b0010);
        hard_reset();
        tick();
        chk("rif_estado", 32'(estado), 32'd0);
        do_init(4'd6, 4'd2);
        load(0, 6'b00_1100); load(1, 6'b01_1101); load(2, 6'b10_1110); load(3, 6'b11_1111);
        tick_pop("ptr_idle", 4'b0000);
        tick_pop("ptr_pop0", 4'b0001);
        tick_pop("ptr_pop1", 4'b0010);
        tick_pop("ptr_pop2", 4'b0100);
        tick_pop("ptr_pop3", 4'b1000);
        tick_pop("ptr_drain0", 4'b0000);
        tick_pop("ptr_drain1", 4'b0000);
        chk("ptr_idle_end", 32'(estado), 32'd2);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
